// File: rtl/jtag_bsr_gen_if.sv
// TAP-side signal bundle for the boundary-scan register: DR control strobes,
// instruction, serial data in/out and the shift-length error flag.
interface jtag_bsr_gen_if;
  logic       capturedr;
  logic       shiftdr;
  logic       updatedr;
  logic [1:0] inst;
  logic       TDI;
  logic       TDO;
  logic       len_err;

  // Master is the TAP controller side; slave is the boundary-scan register.
  modport master (
    output capturedr, shiftdr, updatedr, inst, TDI,
    input  TDO, len_err
  );

  modport slave (
    input  capturedr, shiftdr, updatedr, inst, TDI,
    output TDO, len_err
  );
endinterface

// File: rtl/jtag_bsr_gen.sv
// Boundary-scan register: capture/shift/update chain with EXTEST, SAMPLE/PRELOAD,
// INTEST and BYPASS muxing. Define BSR_LEN_CHECK_EN to add the shift-length checker.
module jtag_bsr_gen #(
  parameter int NUM_IN  = 36,
  parameter int NUM_OUT = 39
) (
  input  logic               TCLK,
  input  logic               TRST,
  jtag_bsr_gen_if.slave      tap,
  input  logic [NUM_IN-1:0]  pin_in,
  output logic [NUM_IN-1:0]  core_in,
  input  logic [NUM_OUT-1:0] core_out,
  output logic [NUM_OUT-1:0] pin_out
);

  localparam int L = NUM_IN + NUM_OUT;

  typedef enum logic [1:0] {
    EXTEST = 2'b00,
    SAMPLE = 2'b01,
    INTEST = 2'b10,
    BYPASS = 2'b11
  } inst_e;

  inst_e          mode;
  logic           bsr_sel;
  logic [L-1:0]   sr;
  logic [L-1:0]   sr_next;
  logic [L-1:0]   ur;
  logic           bp;
  logic           bp_next;

  assign mode    = inst_e'(tap.inst);
  assign bsr_sel = (mode != BYPASS);

  // Capture outranks shift; in BYPASS the boundary chain is frozen.
  always_comb begin
    sr_next = sr;
    if (bsr_sel) begin
      if (tap.capturedr) begin
        sr_next = {core_out, pin_in};
      end else if (tap.shiftdr) begin
        sr_next = {sr[L-2:0], tap.TDI};
      end
    end
  end

  always_comb begin
    bp_next = bp;
    if (!bsr_sel) begin
      if (tap.capturedr) begin
        bp_next = 1'b0;
      end else if (tap.shiftdr) begin
        bp_next = tap.TDI;
      end
    end
  end

  always_ff @(posedge TCLK or negedge TRST) begin
    if (!TRST) begin
      sr <= '0;
      bp <= 1'b0;
    end else begin
      sr <= sr_next;
      bp <= bp_next;
    end
  end

  // UR latches the pre-edge SR, so an update coinciding with a shift or capture sees the old frame.
  always_ff @(posedge TCLK or negedge TRST) begin
    if (!TRST) begin
      ur <= '0;
    end else if (tap.updatedr && bsr_sel) begin
      ur <= sr;
    end
  end

  assign tap.TDO = bsr_sel ? sr[L-1] : bp;

  always_comb begin
    core_in = pin_in;
    pin_out = core_out;
    case (mode)
      EXTEST: begin
        pin_out = ur[L-1:NUM_IN];
      end
      INTEST: begin
        core_in = ur[NUM_IN-1:0];
        pin_out = ur[L-1:NUM_IN];
      end
      default: begin
        core_in = pin_in;
        pin_out = core_out;
      end
    endcase
  end

`ifdef BSR_LEN_CHECK_EN
  localparam int             CW      = $clog2(L + 2);
  localparam logic [CW-1:0]  CNT_MAX = CW'(L + 1);
  localparam logic [CW-1:0]  LEN_BSR = CW'(L);
  localparam logic [CW-1:0]  LEN_BYP = CW'(1);

  logic [CW-1:0] cnt;
  logic          len_err_q;

  // Counts shifts in any mode, so a BYPASS frame is judged against a length of one.
  always_ff @(posedge TCLK or negedge TRST) begin
    if (!TRST) begin
      cnt <= '0;
    end else if (tap.capturedr) begin
      cnt <= '0;
    end else if (tap.shiftdr && (cnt != CNT_MAX)) begin
      cnt <= cnt + CW'(1);
    end
  end

  always_ff @(posedge TCLK or negedge TRST) begin
    if (!TRST) begin
      len_err_q <= 1'b0;
    end else if (tap.updatedr) begin
      len_err_q <= (cnt != (bsr_sel ? LEN_BSR : LEN_BYP));
    end
  end

  assign tap.len_err = len_err_q;
`else
  assign tap.len_err = 1'b0;
`endif

endmodule

// File: tb/tb_jtag_bsr_gen.sv
// Self-checking bench for jtag_bsr_gen (NUM_IN=4, NUM_OUT=4): directed frames
// followed by randomized TAP traffic compared against a queue-based model.
module tb_jtag_bsr_gen;

  localparam int NUM_IN  = 4;
  localparam int NUM_OUT = 4;
  localparam int L       = NUM_IN + NUM_OUT;

`ifdef BSR_LEN_CHECK_EN
  localparam bit LEN_EN = 1'b1;
`else
  localparam bit LEN_EN = 1'b0;
`endif

  logic               TCLK;
  logic               TRST;
  logic [NUM_IN-1:0]  pin_in;
  logic [NUM_IN-1:0]  core_in;
  logic [NUM_OUT-1:0] core_out;
  logic [NUM_OUT-1:0] pin_out;

  jtag_bsr_gen_if tap();

  jtag_bsr_gen #(.NUM_IN(NUM_IN), .NUM_OUT(NUM_OUT)) dut (
    .TCLK     (TCLK),
    .TRST     (TRST),
    .tap      (tap),
    .pin_in   (pin_in),
    .core_in  (core_in),
    .core_out (core_out),
    .pin_out  (pin_out)
  );

  initial begin
    TCLK = 1'b0;
    forever #5 TCLK = ~TCLK;
  end

  int checks = 0;
  int errors = 0;

  // Reference model: the scan chain as a queue, index 0 nearest TDI.
  bit m_sr[$];
  bit m_ur[L];
  bit m_bp;
  int m_shifts;
  bit m_lenerr;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  function automatic void model_reset();
    m_sr.delete();
    for (int i = 0; i < L; i++) m_sr.push_back(1'b0);
    for (int i = 0; i < L; i++) m_ur[i] = 1'b0;
    m_bp     = 1'b0;
    m_shifts = 0;
    m_lenerr = 1'b0;
  endfunction

  function automatic logic exp_tdo(input logic [1:0] ins);
    return (ins == 2'b11) ? m_bp : m_sr[L-1];
  endfunction

  function automatic logic [NUM_OUT-1:0] exp_pin_out(input logic [1:0] ins);
    logic [NUM_OUT-1:0] r;
    r = core_out;
    if (ins == 2'b00 || ins == 2'b10)
      for (int j = 0; j < NUM_OUT; j++) r[j] = m_ur[NUM_IN+j];
    return r;
  endfunction

  function automatic logic [NUM_IN-1:0] exp_core_in(input logic [1:0] ins);
    logic [NUM_IN-1:0] r;
    r = pin_in;
    if (ins == 2'b10)
      for (int j = 0; j < NUM_IN; j++) r[j] = m_ur[j];
    return r;
  endfunction

  function automatic void model_edge(input bit cap, input bit sh, input bit upd,
                                     input logic [1:0] ins, input bit tdi);
    bit old_sr[L];
    int old_shifts;
    bit byp;
    byp        = (ins == 2'b11);
    old_shifts = m_shifts;
    for (int i = 0; i < L; i++) old_sr[i] = m_sr[i];
    if (byp) begin
      if (cap) m_bp = 1'b0;
      else if (sh) m_bp = tdi;
    end else begin
      if (cap) begin
        for (int i = 0; i < L; i++)
          m_sr[i] = (i < NUM_IN) ? pin_in[i] : core_out[i-NUM_IN];
      end else if (sh) begin
        m_sr.push_front(tdi);
        void'(m_sr.pop_back());
      end
      if (upd) for (int i = 0; i < L; i++) m_ur[i] = old_sr[i];
    end
    if (cap) m_shifts = 0;
    else if (sh && m_shifts < L + 1) m_shifts++;
    if (upd && LEN_EN) m_lenerr = (old_shifts != (byp ? 1 : L));
  endfunction

  task automatic applyStimulus(input bit cap, input bit sh, input bit upd,
                               input logic [1:0] ins, input bit tdi);
    tap.capturedr = cap;
    tap.shiftdr   = sh;
    tap.updatedr  = upd;
    tap.inst      = ins;
    tap.TDI       = tdi;
    #1;
    checkOutput("tdo_pre", tap.TDO, exp_tdo(ins));
    checkOutput("pin_out_pre", pin_out, exp_pin_out(ins));
    checkOutput("core_in_pre", core_in, exp_core_in(ins));
    model_edge(cap, sh, upd, ins, tdi);
    @(posedge TCLK);
    #1;
    checkOutput("tdo_post", tap.TDO, exp_tdo(ins));
    checkOutput("pin_out_post", pin_out, exp_pin_out(ins));
    checkOutput("core_in_post", core_in, exp_core_in(ins));
    checkOutput("len_err", tap.len_err, m_lenerr);
  endtask

  task automatic doReset();
    TRST = 1'b0;
    #1;
    model_reset();
    checkOutput("rst_tdo", tap.TDO, 1'b0);
    checkOutput("rst_len_err", tap.len_err, 1'b0);
    checkOutput("rst_pin_out", pin_out, exp_pin_out(tap.inst));
    checkOutput("rst_core_in", core_in, exp_core_in(tap.inst));
    #1;
    TRST = 1'b1;
  endtask

  initial begin
    logic [7:0] seq;
    logic [7:0] frame;
    logic [2:0] bits3;
    logic       prev;
    logic [1:0] ins;
    bit cap, sh, upd;

    TRST          = 1'b0;
    tap.capturedr = 1'b0;
    tap.shiftdr   = 1'b0;
    tap.updatedr  = 1'b0;
    tap.inst      = 2'b00;
    tap.TDI       = 1'b0;
    pin_in        = 4'h7;
    core_out      = 4'hB;
    model_reset();
    #3;
    checkOutput("reset_tdo", tap.TDO, 1'b0);
    checkOutput("reset_extest_pin_out", pin_out, 4'h0);
    checkOutput("reset_len_err", tap.len_err, 1'b0);
    tap.inst = 2'b10;
    #1;
    checkOutput("reset_intest_core_in", core_in, 4'h0);
    TRST = 1'b1;
    @(posedge TCLK);
    #1;

    // Bypass: 3-bit frame flags an error, 1-bit frame does not.
    core_out = 4'h3;
    applyStimulus(1, 0, 0, 2'b11, 0);
    bits3 = 3'b101;
    prev  = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checkOutput("byp_tdo", tap.TDO, prev);
      checkOutput("byp_pin_out", pin_out, 4'h3);
      applyStimulus(0, 1, 0, 2'b11, bits3[2-k]);
      prev = bits3[2-k];
    end
    applyStimulus(0, 0, 1, 2'b11, 0);
    checkOutput("byp_len3", tap.len_err, LEN_EN);
    applyStimulus(1, 0, 0, 2'b11, 0);
    applyStimulus(0, 1, 0, 2'b11, 1);
    applyStimulus(0, 0, 1, 2'b11, 0);
    checkOutput("byp_len1", tap.len_err, 1'b0);

    // SAMPLE: captured frame appears MSB-first on TDO.
    pin_in   = 4'hA;
    core_out = 4'h5;
    applyStimulus(1, 0, 0, 2'b01, 0);
    seq = 8'b0101_1010;
    for (int k = 0; k < 8; k++) begin
      checkOutput("sample_tdo", tap.TDO, seq[7-k]);
      checkOutput("sample_pin_out", pin_out, 4'h5);
      applyStimulus(0, 1, 0, 2'b01, 0);
    end

    // PRELOAD then EXTEST drives the preloaded output cells.
    applyStimulus(1, 0, 0, 2'b01, 0);
    frame = 8'hC3;
    for (int k = 7; k >= 0; k--) applyStimulus(0, 1, 0, 2'b01, frame[k]);
    applyStimulus(0, 0, 1, 2'b01, 0);
    applyStimulus(0, 0, 0, 2'b00, 0);
    checkOutput("extest_pin_out", pin_out, 4'hC);
    checkOutput("extest_core_in", core_in, pin_in);
    checkOutput("extest_len_err", tap.len_err, 1'b0);

    // INTEST: full frame then a short frame.
    applyStimulus(1, 0, 0, 2'b10, 0);
    frame = 8'h96;
    for (int k = 7; k >= 0; k--) applyStimulus(0, 1, 0, 2'b10, frame[k]);
    applyStimulus(0, 0, 1, 2'b10, 0);
    checkOutput("intest_core_in", core_in, 4'h6);
    checkOutput("intest_pin_out", pin_out, 4'h9);
    checkOutput("intest_len8", tap.len_err, 1'b0);
    applyStimulus(1, 0, 0, 2'b10, 0);
    for (int k = 0; k < 7; k++) applyStimulus(0, 1, 0, 2'b10, 1);
    applyStimulus(0, 0, 1, 2'b10, 0);
    checkOutput("intest_len7", tap.len_err, LEN_EN);

    // Capture beats shift; update alongside shift takes the pre-shift frame.
    pin_in   = 4'h0;
    core_out = 4'h8;
    applyStimulus(1, 1, 0, 2'b01, 1);
    checkOutput("cap_over_shift_tdo", tap.TDO, 1'b1);
    applyStimulus(0, 1, 1, 2'b00, 0);
    checkOutput("upd_pre_shift_pin_out", pin_out, 4'h8);
    checkOutput("upd_shift_len_err", tap.len_err, LEN_EN);

    // Reset in the middle of an EXTEST frame.
    core_out = 4'hF;
    applyStimulus(1, 0, 0, 2'b00, 0);
    for (int k = 0; k < 3; k++) applyStimulus(0, 1, 0, 2'b00, 1);
    doReset();
    checkOutput("midrst_pin_out", pin_out, 4'h0);
    checkOutput("midrst_tdo", tap.TDO, 1'b0);

    // Randomized traffic against the model.
    ins = 2'b01;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 9) == 0) ins = 2'($urandom_range(0, 3));
      pin_in   = 4'($urandom);
      core_out = 4'($urandom);
      cap = ($urandom_range(0, 99) < 12);
      sh  = ($urandom_range(0, 99) < 70);
      upd = ($urandom_range(0, 99) < 12);
      if ($urandom_range(0, 199) == 0) doReset();
      applyStimulus(cap, sh, upd, ins, 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
